// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the async-FIFO write-side arbiter: FSM encoding and requester IDs.
package fifo_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_B0 = 2'd1,
    ST_SEND_B1 = 2'd2
  } state_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_RF  = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Two-way round-robin grant: on contention the requester that did not win last time is chosen.
module rr_arbiter_2
  import fifo_wr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = (last_grant == REQ_RF) ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller sharing one FIFO write port between a 2-byte ALU word and a 1-byte RF read.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               REQ0_VLD,
  input  logic [2*WIDTH-1:0] REQ0_DATA,
  output logic               REQ0_ACK,
  input  logic               REQ1_VLD,
  input  logic [WIDTH-1:0]   REQ1_DATA,
  output logic               REQ1_ACK,
  input  logic               FULL,
  output logic               W_INC,
  output logic [WIDTH-1:0]   WR_DATA,
  output logic               BUSY,
  output logic               GRANT_ID
);

  localparam int unsigned WORD_W = 2 * WIDTH;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                two_byte_q, two_byte_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_id_q, grant_id_d;
  logic [WIDTH-1:0]    wr_data_q;
  logic [WIDTH-1:0]    wr_data_c;
  logic                w_inc_c;
  logic [1:0]          grant_c;
  logic [WIDTH-1:0]    lo_byte, hi_byte;

  assign lo_byte = hold_q[WIDTH-1:0];
  assign hi_byte = hold_q[WORD_W-1:WIDTH];

  // ACKs are only offered while idle and never during reset
  rr_arbiter_2 u_rr (
    .req        ({REQ1_VLD, REQ0_VLD}),
    .last_grant (last_grant_q),
    .enable     ((state_q == ST_IDLE) && RST_n),
    .grant_c    (grant_c)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    two_byte_d   = two_byte_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    w_inc_c      = 1'b0;
    wr_data_c    = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_c[0]) begin
          hold_d       = REQ0_DATA;
          two_byte_d   = 1'b1;
          last_grant_d = REQ_ALU;
          grant_id_d   = REQ_ALU;
          state_d      = ST_SEND_B0;
        end else if (grant_c[1]) begin
          hold_d       = {{WIDTH{1'b0}}, REQ1_DATA};
          two_byte_d   = 1'b0;
          last_grant_d = REQ_RF;
          grant_id_d   = REQ_RF;
          state_d      = ST_SEND_B0;
        end
      end
      ST_SEND_B0: begin
        wr_data_c = (two_byte_q && !LSB_FIRST) ? hi_byte : lo_byte;
        w_inc_c   = !FULL;
        if (!FULL) state_d = two_byte_q ? ST_SEND_B1 : ST_IDLE;
      end
      ST_SEND_B1: begin
        // second half of the word; no grant possible until it is out
        wr_data_c = LSB_FIRST ? hi_byte : lo_byte;
        w_inc_c   = !FULL;
        if (!FULL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      two_byte_q   <= 1'b0;
      last_grant_q <= REQ_RF;
      grant_id_q   <= REQ_ALU;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      two_byte_q   <= two_byte_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      wr_data_q    <= wr_data_c;
    end
  end

  assign REQ0_ACK = grant_c[0];
  assign REQ1_ACK = grant_c[1];
  assign W_INC    = w_inc_c;
  assign WR_DATA  = wr_data_c;
  assign BUSY     = (state_q != ST_IDLE);
  assign GRANT_ID = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: byte-queue reference model checked every cycle, plus directed write-log checks.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_vld, req1_vld, full;
  logic [15:0] req0_data;
  logic [7:0]  req1_data;
  logic        req0_ack, req1_ack, w_inc, busy, grant_id;
  logic [7:0]  wr_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  logic        acc0 = 1'b0, acc1 = 1'b0;

  // reference model: pending bytes of the captured item, in FIFO order
  logic [7:0]  m_q[$];
  logic        m_last  = 1'b1;
  logic        m_gid   = 1'b0;
  logic [7:0]  m_shown = 8'h00;
  logic        win_v, win;
  logic [7:0]  exp_wd;

  logic [7:0]  wlog[$];
  int          wcyc[$];
  logic [7:0]  exp_q[$];

  fifo_wr_arbiter #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .CLK       (clk),
    .RST_n     (rst_n),
    .REQ0_VLD  (req0_vld),
    .REQ0_DATA (req0_data),
    .REQ0_ACK  (req0_ack),
    .REQ1_VLD  (req1_vld),
    .REQ1_DATA (req1_data),
    .REQ1_ACK  (req1_ack),
    .FULL      (full),
    .W_INC     (w_inc),
    .WR_DATA   (wr_data),
    .BUSY      (busy),
    .GRANT_ID  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, 32'(wlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wlog.size()) chk({name, "_byte"}, 32'(wlog[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_log();
    wlog.delete();
    wcyc.delete();
  endtask

  task automatic drive0(input int n, input logic [15:0] d);
    int guard = 0;
    req0_data = d;
    req0_vld  = 1'b1;
    while (n > 0 && guard < 200) begin
      @(posedge clk);
      if (acc0) n--;
      guard++;
      #1;
    end
    req0_vld = 1'b0;
    chk("drv0_items_left", 32'(n), 32'd0);
  endtask

  task automatic drive1(input int n, input logic [7:0] d);
    int guard = 0;
    req1_data = d;
    req1_vld  = 1'b1;
    while (n > 0 && guard < 200) begin
      @(posedge clk);
      if (acc1) n--;
      guard++;
      #1;
    end
    req1_vld = 1'b0;
    chk("drv1_items_left", 32'(n), 32'd0);
  endtask

  // per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_ack0", 32'(req0_ack), 32'd0);
      chk("rst_ack1", 32'(req1_ack), 32'd0);
      chk("rst_w_inc", 32'(w_inc), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      m_q.delete();
      m_last  = 1'b1;
      m_gid   = 1'b0;
      m_shown = 8'h00;
      acc0    = 1'b0;
      acc1    = 1'b0;
    end else begin
      win_v = 1'b0;
      win   = 1'b0;
      if (m_q.size() == 0) begin
        if (req0_vld && req1_vld) begin win_v = 1'b1; win = ~m_last; end
        else if (req0_vld) begin win_v = 1'b1; win = 1'b0; end
        else if (req1_vld) begin win_v = 1'b1; win = 1'b1; end
      end
      exp_wd = (m_q.size() != 0) ? m_q[0] : m_shown;
      chk("ack0", 32'(req0_ack), 32'(win_v && !win));
      chk("ack1", 32'(req1_ack), 32'(win_v && win));
      chk("w_inc", 32'(w_inc), 32'((m_q.size() != 0) && !full));
      chk("wr_data", 32'(wr_data), 32'(exp_wd));
      chk("busy", 32'(busy), 32'(m_q.size() != 0));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      if (w_inc) begin
        wlog.push_back(wr_data);
        wcyc.push_back(cyc);
      end
      acc0 = req0_vld && req0_ack;
      acc1 = req1_vld && req1_ack;
      if (acc0 || acc1) acc_cyc = cyc;
      if (m_q.size() != 0) begin
        m_shown = m_q[0];
        if (!full) void'(m_q.pop_front());
      end else if (win_v) begin
        if (!win) begin
          m_q.push_back(req0_data[7:0]);
          m_q.push_back(req0_data[15:8]);
        end else begin
          m_q.push_back(req1_data);
        end
        m_last = win;
        m_gid  = win;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0; full = 1'b0;
    req0_data = 16'h0; req1_data = 8'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wr_data", 32'(wr_data), 32'd0);
    chk("post_rst_grant_id", 32'(grant_id), 32'd0);

    // single word, low byte first
    clear_log();
    drive0(1, 16'hA55A);
    repeat (4) step();
    exp_q = '{8'h5A, 8'hA5};
    chk_log("word");
    if (wcyc.size() >= 2) begin
      chk("word_lat_b0", 32'(wcyc[0]), 32'(acc_cyc + 1));
      chk("word_lat_b1", 32'(wcyc[1]), 32'(acc_cyc + 2));
    end

    // single byte
    clear_log();
    drive1(1, 8'h3C);
    repeat (3) step();
    exp_q = '{8'h3C};
    chk_log("byte");
    chk("byte_grant_id", 32'(grant_id), 32'd1);

    // continuous contention alternates owners
    clear_log();
    fork
      drive0(2, 16'h1122);
      drive1(2, 8'h33);
    join
    repeat (4) step();
    exp_q = '{8'h22, 8'h11, 8'h33, 8'h22, 8'h11, 8'h33};
    chk_log("contend");

    // FULL rises after the first byte for four cycles; REQ1 waits
    clear_log();
    req0_data = 16'hBEEF; req0_vld = 1'b1;
    step();
    req0_vld = 1'b0; req1_data = 8'h44; req1_vld = 1'b1;
    step();
    full = 1'b1;
    repeat (4) step();
    full = 1'b0;
    step();
    step();
    req1_vld = 1'b0;
    repeat (3) step();
    exp_q = '{8'hEF, 8'hBE, 8'h44};
    chk_log("stall");
    if (wcyc.size() >= 2) begin
      chk("stall_gap", 32'(wcyc[1] - wcyc[0]), 32'd5);
      chk("stall_rf_ack", 32'(acc_cyc), 32'(wcyc[1] + 1));
    end

    // FULL already high when the byte is granted
    clear_log();
    full = 1'b1; req1_data = 8'h77; req1_vld = 1'b1;
    step();
    req1_vld = 1'b0;
    repeat (3) step();
    chk("full_accept_no_write", 32'(wlog.size()), 32'd0);
    full = 1'b0;
    repeat (3) step();
    exp_q = '{8'h77};
    chk_log("full_accept");

    // reset in the middle of a word
    req0_data = 16'h5566; req0_vld = 1'b1;
    step();
    req0_vld = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_w_inc", 32'(w_inc), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_wr_data", 32'(wr_data), 32'd0);
    step();
    rst_n = 1'b1;
    clear_log();
    fork
      drive0(1, 16'h0102);
      drive1(1, 8'h99);
    join
    repeat (4) step();
    exp_q = '{8'h02, 8'h01, 8'h99};
    chk_log("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
